fetch: RTL

Instruction fetch stage: the producer end of the opcode byte stream that the decode stage consumes. It holds the program counter and issues one read per cycle to a synchronous instruction memory with 1-cycle latency. Returned bytes go into a 2-entry prefetch buffer, which is presented to decode as `opcode` / `opcode_valid` and honours decode's `stall_en` backpressure. Branch and jump targets from execute arrive as a redirect, which flushes everything fetched but not yet consumed.

---
 rtl/smolproc_pkg.sv | 13 +
 rtl/fetch_buf.sv | 69 ++++++
 rtl/fetch.sv | 77 +++++++
 3 files changed

// File: rtl/smolproc_pkg.sv
// Shared definitions for the smolproc pipeline: address width, reset vector
// and the {byte, address} pair carried from fetch to decode.
package smolproc_pkg;

  localparam int              PC_W     = 8;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [7:0]      data;
    logic [PC_W-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry prefetch FIFO of {byte, address} pairs between instruction memory
// and decode. Flush empties it in one cycle and wins over push and pop.
module fetch_buf
  import smolproc_pkg::*;
(
  input  logic         clk,
  input  logic         async_rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t entry_q [2];
  fetch_entry_t entry_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_pop  = pop_i && !flush_i && (count_q != 2'd0);
    do_push = push_i && !flush_i && ((count_q != 2'd2) || do_pop);

    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        entry_d[wr_ptr_q] = push_entry_i;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // An empty buffer presents zeros so decode never sees a stale byte.
  assign head_o  = (count_q != 2'd0) ? entry_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: program counter, one read per cycle to a 1-cycle-latency
// memory, and redirect handling. PC_W must match smolproc_pkg::PC_W.
module fetch #(
  parameter int              PC_W     = smolproc_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(smolproc_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            async_rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  input  logic            stall_en,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [7:0]      opcode,
  output logic            opcode_valid,
  output logic [PC_W-1:0] opcode_pc
);

  import smolproc_pkg::*;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            inflight_q;
  logic [PC_W-1:0] req_addr_q;
  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            push;
  logic            room;
  logic [2:0]      occupancy;

  always_comb begin
    pop       = (count != 2'd0) && !stall_en && !redirect_en;
    push      = inflight_q && !redirect_en;
    occupancy = {1'b0, count} + {2'b00, inflight_q};
    // Issue only if the slot freed by this cycle's pop keeps the buffer from overflowing.
    room      = occupancy < (3'd2 + {2'b00, pop});
    imem_req  = async_rst_n && (redirect_en || room);
    imem_addr = redirect_en ? redirect_pc : pc_q;
    pc_d      = imem_req ? imem_addr + 1'b1 : pc_q;

    push_entry      = '0;
    push_entry.data = imem_data;
    push_entry.addr = req_addr_q;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      req_addr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= imem_req;
      if (imem_req) begin
        req_addr_q <= imem_addr;
      end
    end
  end

  fetch_buf u_buf (
    .clk          (clk),
    .async_rst_n  (async_rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_en),
    .count_o      (count),
    .head_o       (head)
  );

  assign opcode       = head.data;
  assign opcode_pc    = head.addr;
  assign opcode_valid = (count != 2'd0);

endmodule
